// File: rtl/usb_audio_play_ctrl.sv
// Playback scheduler: OUT bytes -> stereo frame FIFO -> paced DAC samples.
// Define FILL_ADJUST_EN to trim the sample period from the FIFO fill level.
module usb_audio_play_ctrl #(
  parameter int unsigned CLK_HZ     = 60000000,
  parameter int unsigned SAMPLE_HZ  = 48000,
  parameter int unsigned DEPTH_LOG2 = 8,
  parameter int unsigned PREFILL    = 96
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                enable,
  input  logic                pkt_start,
  input  logic [7:0]          out_data,
  input  logic                out_valid,
  input  logic                clr_flags,
  output logic [15:0]         audio_L_ch,
  output logic [15:0]         audio_R_ch,
  output logic                sample_tick,
  output logic [DEPTH_LOG2:0] fifo_level,
  output logic [1:0]          state,
  output logic                ovf_flag,
  output logic                udr_flag
);
  localparam int unsigned P     = CLK_HZ / SAMPLE_HZ;
  localparam int unsigned DEPTH = 1 << DEPTH_LOG2;
  localparam int unsigned CW    = $clog2(P + 2);
  localparam logic [CW-1:0] PER_NOM = CW'(P);
`ifdef FILL_ADJUST_EN
  localparam logic [CW-1:0] PER_FAST = CW'(P - 1);
  localparam logic [CW-1:0] PER_SLOW = CW'(P + 1);
`endif

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    PREF = 2'd1,
    PLAY = 2'd2,
    UNDR = 2'd3
  } st_e;

  st_e                 st_q;
  logic [31:0]         mem_q [DEPTH];
  logic [DEPTH_LOG2:0] wptr_q, rptr_q, level;
  logic [31:0]         lvl32;
  logic [1:0]          ph_q, ph;
  logic [23:0]         sr_q;
  logic [31:0]         wfr_q, rfr;
  logic                wpend_q;
  logic [CW-1:0]       cnt_q, per_q, per_d;
  logic [15:0]         l_q, r_q;
  logic                tick_q, ovf_q, udr_q;
  logic                tick, full, wr_ok, rd, prefilled;
  logic                ovf_set, udr_set;

  always_comb begin
    level     = wptr_q - rptr_q;
    lvl32     = 32'(level);
    full      = lvl32 == DEPTH;
    prefilled = lvl32 >= PREFILL;
    wr_ok     = enable && wpend_q && !full;
    ovf_set   = enable && wpend_q && full;
    tick      = (st_q != IDLE) && (cnt_q == per_q - CW'(1));
    rd        = enable && tick && (st_q == PLAY) && (level != '0);
    udr_set   = enable && tick && (st_q == PLAY) && (level == '0);
    rfr       = mem_q[rptr_q[DEPTH_LOG2-1:0]];
    ph        = pkt_start ? 2'd0 : ph_q;
    per_d     = PER_NOM;
`ifdef FILL_ADJUST_EN
    // Fill-level feedback only while playing, to follow host clock drift.
    if (st_q == PLAY) begin
      if (lvl32 > (DEPTH * 3) / 4)
        per_d = PER_FAST;
      else if (lvl32 < DEPTH / 4)
        per_d = PER_SLOW;
    end
`endif
  end

  always_ff @(posedge clk) begin
    if (wr_ok)
      mem_q[wptr_q[DEPTH_LOG2-1:0]] <= wfr_q;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      st_q    <= IDLE;
      wptr_q  <= '0;
      rptr_q  <= '0;
      ph_q    <= '0;
      sr_q    <= '0;
      wfr_q   <= '0;
      wpend_q <= 1'b0;
      cnt_q   <= '0;
      per_q   <= PER_NOM;
      l_q     <= '0;
      r_q     <= '0;
      tick_q  <= 1'b0;
      ovf_q   <= 1'b0;
      udr_q   <= 1'b0;
    end else begin
      tick_q  <= 1'b0;
      wpend_q <= 1'b0;
      ovf_q   <= ovf_set || (ovf_q && !clr_flags);
      udr_q   <= udr_set || (udr_q && !clr_flags);
      if (!enable) begin
        st_q   <= IDLE;
        wptr_q <= '0;
        rptr_q <= '0;
        ph_q   <= '0;
        cnt_q  <= '0;
        per_q  <= PER_NOM;
        l_q    <= '0;
        r_q    <= '0;
      end else begin
        if (out_valid) begin
          unique case (ph)
            2'd0: sr_q[7:0]   <= out_data;
            2'd1: sr_q[15:8]  <= out_data;
            2'd2: sr_q[23:16] <= out_data;
            2'd3: begin
              wfr_q   <= {out_data, sr_q};
              wpend_q <= 1'b1;
            end
          endcase
          ph_q <= ph + 2'd1;
        end else if (pkt_start) begin
          ph_q <= 2'd0;
        end
        if (wr_ok)
          wptr_q <= wptr_q + 1'b1;
        if (rd)
          rptr_q <= rptr_q + 1'b1;
        cnt_q <= (st_q == IDLE || tick) ? '0 : cnt_q + CW'(1);
        if (tick)
          per_q <= per_d;
        unique case (st_q)
          IDLE: st_q <= PREF;
          PREF: if (prefilled) st_q <= PLAY;
          PLAY: begin
            if (tick) begin
              tick_q <= 1'b1;
              if (level != '0) begin
                l_q <= rfr[15:0];
                r_q <= rfr[31:16];
              end else begin
                st_q <= UNDR;
                l_q  <= '0;
                r_q  <= '0;
              end
            end
          end
          UNDR: begin
            if (tick) begin
              tick_q <= 1'b1;
              l_q    <= '0;
              r_q    <= '0;
            end
            if (prefilled)
              st_q <= PLAY;
          end
        endcase
      end
    end
  end

  assign audio_L_ch  = l_q;
  assign audio_R_ch  = r_q;
  assign sample_tick = tick_q;
  assign fifo_level  = level;
  assign state       = st_q;
  assign ovf_flag    = ovf_q;
  assign udr_flag    = udr_q;

endmodule

// File: tb/tb_usb_audio_play_ctrl.sv
// Bench for usb_audio_play_ctrl: random streaming against a queue-based model.
// Honours FILL_ADJUST_EN when computing expected sample periods.
module tb_usb_audio_play_ctrl;
  localparam int P     = 60000000 / 48000;
  localparam int DEPTH = 256;
  localparam int PRE   = 16;
`ifdef FILL_ADJUST_EN
  localparam int EXP_HI = P - 1;
  localparam int EXP_LO = P + 1;
`else
  localparam int EXP_HI = P;
  localparam int EXP_LO = P;
`endif

  logic        clk = 1'b0;
  logic        rst;
  logic        enable;
  logic        pkt_start;
  logic [7:0]  out_data;
  logic        out_valid;
  logic        clr_flags;
  logic [15:0] audio_L_ch, audio_R_ch;
  logic        sample_tick;
  logic [8:0]  fifo_level;
  logic [1:0]  state;
  logic        ovf_flag, udr_flag;

  usb_audio_play_ctrl #(
    .CLK_HZ(60000000),
    .SAMPLE_HZ(48000),
    .DEPTH_LOG2(8),
    .PREFILL(PRE)
  ) dut (
    .clk(clk),
    .rst(rst),
    .enable(enable),
    .pkt_start(pkt_start),
    .out_data(out_data),
    .out_valid(out_valid),
    .clr_flags(clr_flags),
    .audio_L_ch(audio_L_ch),
    .audio_R_ch(audio_R_ch),
    .sample_tick(sample_tick),
    .fifo_level(fifo_level),
    .state(state),
    .ovf_flag(ovf_flag),
    .udr_flag(udr_flag)
  );

  always #5 clk = ~clk;

  int n_chk = 0;
  int n_err = 0;
  int cyc   = 0;

  // Reference model: frames in a queue, bytes in a queue, ticks by countdown.
  logic [31:0] m_fifo[$];
  logic [7:0]  m_bytes[$];
  bit          m_pend;
  logic [31:0] m_pfr;
  int          m_st;
  int          m_togo;
  logic [15:0] m_L, m_R;
  bit          m_tick, m_ovf, m_udr;

  task automatic finish_run();
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  endtask

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)",
               tag, got, exp, cyc);
    end
  endtask

  task automatic model_reset();
    m_fifo.delete();
    m_bytes.delete();
    m_pend = 0;
    m_pfr  = '0;
    m_st   = 0;
    m_togo = P - 1;
    m_L    = '0;
    m_R    = '0;
    m_tick = 0;
    m_ovf  = 0;
    m_udr  = 0;
  endtask

  task automatic model_step(input bit en, input bit ps, input bit dv,
                            input logic [7:0] d, input bit clr);
    int          lvl;
    bit          tk, pend_now, drop, miss;
    logic [31:0] pfr, f;
    int          per;
    lvl      = m_fifo.size();
    tk       = (m_st != 0) && (m_togo == 0);
    pend_now = m_pend;
    pfr      = m_pfr;
    m_tick   = 0;
    m_pend   = 0;
    if (!en) begin
      m_st = 0;
      m_fifo.delete();
      m_bytes.delete();
      m_togo = P - 1;
      m_L = '0;
      m_R = '0;
      m_ovf = m_ovf && !clr;
      m_udr = m_udr && !clr;
      return;
    end
    drop  = pend_now && (lvl == DEPTH);
    miss  = tk && (m_st == 2) && (lvl == 0);
    m_ovf = drop || (m_ovf && !clr);
    m_udr = miss || (m_udr && !clr);
    if (tk && m_st == 2) begin
      m_tick = 1;
      if (lvl > 0) begin
        f = m_fifo.pop_front();
        m_L = f[15:0];
        m_R = f[31:16];
      end else begin
        m_L = '0;
        m_R = '0;
      end
    end
    if (tk && m_st == 3) begin
      m_tick = 1;
      m_L = '0;
      m_R = '0;
    end
    if (pend_now && !drop)
      m_fifo.push_back(pfr);
    if (m_st == 0) begin
      m_togo = P - 1;
    end else if (tk) begin
      per = P;
`ifdef FILL_ADJUST_EN
      if (m_st == 2 && lvl > DEPTH * 3 / 4) per = P - 1;
      else if (m_st == 2 && lvl < DEPTH / 4) per = P + 1;
`endif
      m_togo = per - 1;
    end else begin
      m_togo--;
    end
    case (m_st)
      0: m_st = 1;
      1: if (lvl >= PRE) m_st = 2;
      2: if (miss) m_st = 3;
      default: if (lvl >= PRE) m_st = 2;
    endcase
    if (dv) begin
      if (ps) m_bytes.delete();
      m_bytes.push_back(d);
      if (m_bytes.size() == 4) begin
        m_pend = 1;
        m_pfr  = {m_bytes[3], m_bytes[2], m_bytes[1], m_bytes[0]};
        m_bytes.delete();
      end
    end else if (ps) begin
      m_bytes.delete();
    end
  endtask

  bit en_s = 0;

  task automatic step(input bit ps, input bit dv, input logic [7:0] d,
                      input bit clr);
    enable    = en_s;
    pkt_start = ps;
    out_valid = dv;
    out_data  = d;
    clr_flags = clr;
    if (rst) model_reset();
    else model_step(en_s, ps, dv, d, clr);
    @(negedge clk);
    cyc++;
    chk("audio_L", 32'(audio_L_ch), 32'(m_L));
    chk("audio_R", 32'(audio_R_ch), 32'(m_R));
    chk("tick", 32'(sample_tick), 32'(m_tick));
    chk("level", 32'(fifo_level), 32'(m_fifo.size()));
    chk("state", 32'(state), 32'(m_st));
    chk("ovf", 32'(ovf_flag), 32'(m_ovf));
    chk("udr", 32'(udr_flag), 32'(m_udr));
    if (n_err > 40) finish_run();
  endtask

  task automatic idle(input int n);
    repeat (n) step(0, 0, 8'h00, 0);
  endtask

  task automatic send_byte(input logic [7:0] b, input bit ps, input bit fast);
    step(ps, 1, b, 0);
    if (!fast && $urandom_range(0, 3) == 0) idle(1);
  endtask

  task automatic send_frame(input logic [15:0] l, input logic [15:0] r,
                            input bit fast);
    send_byte(l[7:0], ($urandom_range(0, 3) == 0), fast);
    send_byte(l[15:8], 0, fast);
    send_byte(r[7:0], 0, fast);
    send_byte(r[15:8], 0, fast);
  endtask

  task automatic send_rand(input int n, input bit fast);
    repeat (n) send_frame(16'($urandom), 16'($urandom), fast);
  endtask

  task automatic wait_tick(output int at);
    bit got;
    got = 0;
    at  = 0;
    for (int i = 0; i < 1400 && !got; i++) begin
      idle(1);
      if (sample_tick) begin
        got = 1;
        at  = cyc;
      end
    end
    chk("tick_wait", 32'(got), 32'd1);
  endtask

  initial begin
    int t1, t2;
    rst = 1'b1;
    enable = 1'b0;
    pkt_start = 1'b0;
    out_valid = 1'b0;
    out_data = 8'h00;
    clr_flags = 1'b0;
    idle(3);
    chk("rst_state", 32'(state), 32'd0);
    chk("rst_level", 32'(fifo_level), 32'd0);
    chk("rst_outs", {audio_R_ch, audio_L_ch}, 32'd0);
    rst  = 1'b0;
    en_s = 1;

    // Prefill with a fixed pattern, then the first tick plays it.
    repeat (PRE) send_frame(16'h1234, 16'hABCD, 0);
    idle(3);
    chk("prefill_play", 32'(state), 32'd2);
    wait_tick(t1);
    chk("first_L", 32'(audio_L_ch), 32'h1234);
    chk("first_R", 32'(audio_R_ch), 32'hABCD);
    chk("first_level", 32'(fifo_level), 32'(PRE - 1));

    // Realign: partial frame discarded by pkt_start.
    send_byte(8'hA1, 0, 0);
    send_byte(8'hA2, 0, 0);
    send_byte(8'hA3, 0, 0);
    send_byte(8'h11, 1, 0);
    send_byte(8'h22, 0, 0);
    send_byte(8'h33, 0, 0);
    idle(2);
    chk("realign_hold", 32'(fifo_level), 32'(PRE - 1));
    send_byte(8'h44, 0, 0);
    idle(2);
    chk("realign_level", 32'(fifo_level), 32'(PRE));

    // Drain to 10, play 10, then underrun on the 11th tick.
    for (int i = 0; i < 12000 && m_fifo.size() > 10; i++) idle(1);
    repeat (10) wait_tick(t1);
    chk("pre_udr_state", 32'(state), 32'd2);
    wait_tick(t1);
    chk("udr_state", 32'(state), 32'd3);
    chk("udr_flag", 32'(udr_flag), 32'd1);
    chk("udr_outs", {audio_R_ch, audio_L_ch}, 32'd0);
    send_rand(PRE, 0);
    idle(3);
    chk("recover", 32'(state), 32'd2);

    // Overflow while playing, then clear flags.
    send_rand(262, 1);
    idle(2);
    chk("ovf_set", 32'(ovf_flag), 32'd1);
    step(0, 0, 8'h00, 1);
    chk("ovf_clr", 32'(ovf_flag), 32'd0);

    // High fill period.
    wait_tick(t1);
    wait_tick(t2);
    chk("period_hi", 32'(t2 - t1), 32'(EXP_HI));

    // Disable mid-play with 50 frames queued.
    en_s = 0;
    idle(1);
    en_s = 1;
    send_rand(50, 0);
    idle(2);
    chk("lvl50", 32'(fifo_level), 32'd50);
    en_s = 0;
    idle(1);
    chk("dis_state", 32'(state), 32'd0);
    chk("dis_level", 32'(fifo_level), 32'd0);
    chk("dis_outs", {audio_R_ch, audio_L_ch}, 32'd0);
    idle(5);
    en_s = 1;

    // Low fill period.
    send_rand(40, 1);
    wait_tick(t1);
    wait_tick(t2);
    chk("period_lo", 32'(t2 - t1), 32'(EXP_LO));

    // Random traffic.
    for (int i = 0; i < 4000; i++) begin
      if ($urandom_range(0, 499) == 0) en_s = 0;
      else if (!en_s && $urandom_range(0, 7) == 0) en_s = 1;
      step(($urandom_range(0, 15) == 0), ($urandom_range(0, 9) < 6),
           8'($urandom), ($urandom_range(0, 63) == 0));
    end
    finish_run();
  end
endmodule

// File: doc/usb_audio_play_ctrl.md
Name: usb_audio_play_ctrl

Overview:
Playback scheduler between the USB full-speed core's OUT byte stream and the stereo DAC outputs.
- Packs bytes into 16-bit stereo frames and buffers them in a circular frame FIFO.
- Paces FIFO reads with a 48 kHz sample tick derived from clk.
- Sequences start-up prefill, steady playback and underrun recovery.
- Exports fill level and sticky error flags for the descriptor/control logic.

Parameters:
CLK_HZ, 60000000, clk frequency in Hz
SAMPLE_HZ, 48000, output frame rate in Hz
DEPTH_LOG2, 8, log2 of FIFO depth in stereo frames (256 frames)
PREFILL, 96, frames required in FIFO before PLAY starts

Ports:
clk  input  1  system clock, 60 MHz
rst  input  1  synchronous reset, active-high
enable  input  1  streaming interface active (alt setting 1); 0 flushes and idles
pkt_start  input  1  pulse at start of each OUT packet; realigns byte phase
out_data  input  8  OUT payload byte from USB core
out_valid  input  1  out_data valid for one cycle
clr_flags  input  1  clears ovf_flag and udr_flag
audio_L_ch  output  16  left sample, signed two's complement
audio_R_ch  output  16  right sample, signed two's complement
sample_tick  output  1  one-cycle pulse; asserted in the cycle audio_*_ch take a new value
fifo_level  output  DEPTH_LOG2+1  frames currently stored
state  output  2  0=IDLE 1=PREFILL 2=PLAY 3=UNDERRUN
ovf_flag  output  1  sticky: a frame was dropped because the FIFO was full
udr_flag  output  1  sticky: a tick found the FIFO empty in PLAY

Behaviour:
Interface decision: one clock, clk; reset is synchronous and active-high, port rst. No asynchronous reset anywhere.

Reset (rst=1):
- All outputs are 0; state=IDLE.
- Pointers, byte phase and tick counter are cleared.

Byte packing:
- 2-bit byte phase; byte order is L[7:0], L[15:8], R[7:0], R[15:8].
- pkt_start forces phase to 0. If out_valid is high in the same cycle, that byte is taken as phase 0.
- On the phase-3 byte the frame is written to the FIFO in the following cycle, and fifo_level updates in that same cycle.
- Bytes are ignored while enable=0.

FIFO:
- 2^DEPTH_LOG2 entries of 32 bits; wrapping pointers with one extra bit.
- Write while full: the frame is dropped, ovf_flag=1, and level is unchanged.
- Full is evaluated on the pre-cycle level, so a write is dropped even if a read occurs in the same cycle.
- Simultaneous accepted write and read: level is unchanged.

Tick generator:
- Counter reloads every P=CLK_HZ/SAMPLE_HZ cycles (1250).
- A tick fires on reload.
- The counter runs in every state except IDLE, where it is held at 0.

State machine:
- IDLE: outputs are held at 0. On enable=1, go to PREFILL.
- PREFILL: outputs are held at 0. Go to PLAY when fifo_level>=PREFILL.
- PLAY: on each tick, if level>0, pop one frame; audio_L_ch/audio_R_ch register it and sample_tick=1 in the cycle after the tick.
  - If level==0 at the tick (pre-cycle level; a same-cycle write does not count), go to UNDERRUN: udr_flag=1, outputs=0, sample_tick=1.
- UNDERRUN: sample_tick keeps pulsing with outputs 0. Go to PLAY when level>=PREFILL.
- Any state with enable=0: go to IDLE next cycle, flush pointers (level=0), outputs=0.
- Flags: clr_flags clears both flags. A set event in the same cycle wins (flag stays 1).
- sample_tick pulses only in PLAY and UNDERRUN.

Optional Feature:
FILL_ADJUST_EN
- Defined: on each counter reload, the period is chosen from the current level.
  - level > 3/4 depth (192): P-1 (1249).
  - level < 1/4 depth (64): P+1 (1251).
  - Otherwise: P.
  - Adjustment applies only in PLAY; elsewhere P is used. This tracks host clock drift.
- Undefined: the period is fixed at P.

Test Plan:
1. Reset, enable=1, stream 96 frames with L=16'h1234, R=16'hABCD → state 1→2 after the 96th frame is written; first sample_tick 1250 cycles later with audio_L_ch=16'h1234, audio_R_ch=16'hABCD; level=95.
2. PLAY with 10 frames, no writes → 10 ticks with data; the 11th tick gives outputs 0, state=3, udr_flag=1. Then write 96 frames → state=2.
3. Fill 256 frames while in PREFILL (PREFILL parameter set >256 for the test), then write one more → ovf_flag=1, level stays 256. clr_flags → ovf_flag=0.
4. Send 3 bytes, then pkt_start with byte 8'h11 → that byte is L[7:0] of a new frame; the partial frame is discarded and level increases only after 4 aligned bytes.
5. enable dropped mid-PLAY with level=50 → next cycle state=0, level=0, outputs 0, no sample_tick.
6. FILL_ADJUST_EN defined, level held at 200 in PLAY → tick spacing 1249 cycles; at level 40 → 1251; without the macro → 1250 in both cases.
